// File: rtl/operand_dispatcher_pkg.sv
// Shared definitions for the operand dispatcher.
//   - Dispatcher FSM state encoding.
//   - Default operand width and FIFO depth.
// Related build option: OPD_OP_COUNT_EN adds an op_count output to operand_dispatcher.
package operand_dispatcher_pkg;

   localparam int unsigned DEFAULT_WIDTH = 16;
   localparam int unsigned DEFAULT_DEPTH = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StWait  = 2'd2,
      StHold  = 2'd3
   } state_e;

endpackage

// File: rtl/opd_fifo.sv
// Small synchronous FIFO that buffers operand pairs for the dispatcher.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   i_push, i_din  : write strobe and data (caller guarantees no push while full)
//   i_pop, o_dout  : read strobe and head-of-queue data (valid while !o_empty)
//   o_full, o_empty: occupancy flags derived from the entry count
module opd_fifo
   import operand_dispatcher_pkg::*;
#(
   parameter int unsigned DW    = 2 * DEFAULT_WIDTH,
   parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [DW-1:0] i_din,
   output logic [DW-1:0] o_dout,
   output logic          o_full,
   output logic          o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);
   localparam logic [AW:0] CntOne  = (AW + 1)'(1);
   localparam logic [AW-1:0] PtrOne = AW'(1);

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;

   // Storage needs no reset; the count alone defines which entries are live.
   always_ff @(posedge i_clk) begin
      if (i_push) begin
         r_mem[r_wptr] <= i_din;
      end
   end

   // Power-of-2 depth lets the pointers wrap by natural overflow.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_wptr <= r_wptr + PtrOne;
         end
         if (i_pop) begin
            r_rptr <= r_rptr + PtrOne;
         end
         if (i_push && !i_pop) begin
            r_count <= r_count + CntOne;
         end else if (i_pop && !i_push) begin
            r_count <= r_count - CntOne;
         end
      end
   end

   assign o_dout  = r_mem[r_rptr];
   assign o_full  = (r_count == FullCnt);
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/operand_dispatcher.sv
// Operand dispatcher: queues operand pairs, feeds them one at a time to a multiplier core
// (start pulse, wait for done), and presents each product on a valid/ready output.
// Ports:
//   i_clk, i_rst_n                 : clock, asynchronous active-low reset
//   i_in_valid/o_in_ready, i_in_a/b : operand pair input handshake
//   o_core_start, o_core_a/b        : one-cycle start pulse and held operands toward the core
//   i_core_done, i_core_result      : core completion pulse and product
//   o_out_valid/i_out_ready         : result output handshake, o_out_result holds the product
//   o_busy                          : high whenever the FSM is not idle
//   o_op_count (OPD_OP_COUNT_EN)    : wrapping count of results accepted downstream
module operand_dispatcher
   import operand_dispatcher_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_in_valid,
   output logic               o_in_ready,
   input  logic [WIDTH-1:0]   i_in_a,
   input  logic [WIDTH-1:0]   i_in_b,
   output logic               o_core_start,
   output logic [WIDTH-1:0]   o_core_a,
   output logic [WIDTH-1:0]   o_core_b,
   input  logic               i_core_done,
   input  logic [2*WIDTH-1:0] i_core_result,
   output logic               o_out_valid,
   input  logic               i_out_ready,
   output logic [2*WIDTH-1:0] o_out_result,
   output logic               o_busy
`ifdef OPD_OP_COUNT_EN
   ,
   output logic [15:0]        o_op_count
`endif
);

   state_e             r_state;
   logic               r_core_start;
   logic [WIDTH-1:0]   r_core_a;
   logic [WIDTH-1:0]   r_core_b;
   logic               r_out_valid;
   logic [2*WIDTH-1:0] r_out_result;
   logic               r_busy;
`ifdef OPD_OP_COUNT_EN
   logic [15:0]        r_op_count;
`endif

   logic               w_push;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;
   logic [2*WIDTH-1:0] w_head;

   assign w_push     = i_in_valid & ~w_full;
   assign w_pop      = (r_state == StIdle) & ~w_empty;
   assign o_in_ready = ~w_full;

   opd_fifo #(
      .DW    (2 * WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   ({i_in_a, i_in_b}),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Outputs are registered alongside the state so each one is a pure function of the
   // state it belongs to; they are set on entry to that state and cleared on exit.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= StIdle;
         r_core_start <= 1'b0;
         r_core_a     <= '0;
         r_core_b     <= '0;
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_busy       <= 1'b0;
`ifdef OPD_OP_COUNT_EN
         r_op_count   <= '0;
`endif
      end else begin
         r_core_start <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (!w_empty) begin
                  r_core_a     <= w_head[2*WIDTH-1:WIDTH];
                  r_core_b     <= w_head[WIDTH-1:0];
                  r_core_start <= 1'b1;
                  r_busy       <= 1'b1;
                  r_state      <= StStart;
               end
            end
            StStart: begin
               r_state <= StWait;
            end
            StWait: begin
               // Done pulses in any other state are stray and ignored.
               if (i_core_done) begin
                  r_out_result <= i_core_result;
                  r_out_valid  <= 1'b1;
                  r_state      <= StHold;
               end
            end
            StHold: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= StIdle;
`ifdef OPD_OP_COUNT_EN
                  r_op_count  <= r_op_count + 16'd1;
`endif
               end
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign o_core_start = r_core_start;
   assign o_core_a     = r_core_a;
   assign o_core_b     = r_core_b;
   assign o_out_valid  = r_out_valid;
   assign o_out_result = r_out_result;
   assign o_busy       = r_busy;
`ifdef OPD_OP_COUNT_EN
   assign o_op_count   = r_op_count;
`endif

endmodule

// File: tb/tb_operand_dispatcher.sv
// Self-checking bench for operand_dispatcher: directed operand pairs with hand-computed
// products, a behavioural core (done 6 cycles after start), and a scoreboard monitor.
// Build option OPD_OP_COUNT_EN also checks the op_count output.
module tb_operand_dispatcher;

   localparam int unsigned W = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_in_valid;
   logic          o_in_ready;
   logic [W-1:0]  i_in_a;
   logic [W-1:0]  i_in_b;
   logic          o_core_start;
   logic [W-1:0]  o_core_a;
   logic [W-1:0]  o_core_b;
   logic          i_core_done;
   logic [2*W-1:0] i_core_result;
   logic          o_out_valid;
   logic          i_out_ready;
   logic [2*W-1:0] o_out_result;
   logic          o_busy;
`ifdef OPD_OP_COUNT_EN
   logic [15:0]   o_op_count;
`endif

   int            n_checks = 0;
   int            n_pass = 0;
   int            cyc = 0;
   int            start_cnt = 0;
   int            last_start_cyc = 0;
   int            stray_req = 0;
   int            stray_ack = 0;
   int            t_acc = 0;
   logic [31:0]   exp_q [$];

   logic [15:0]   fa [6] = '{16'h0002, 16'h00FF, 16'hFFFF, 16'h0000, 16'h1234, 16'h8000};
   logic [15:0]   fb [6] = '{16'h0007, 16'h0101, 16'hFFFF, 16'hABCD, 16'h0010, 16'h0002};
   logic [31:0]   fe [6] = '{32'h0000_000E, 32'h0000_FFFF, 32'hFFFE_0001, 32'h0000_0000,
                             32'h0001_2340, 32'h0001_0000};

   operand_dispatcher #(
      .WIDTH (16),
      .DEPTH (4)
   ) u_dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_in_valid    (i_in_valid),
      .o_in_ready    (o_in_ready),
      .i_in_a        (i_in_a),
      .i_in_b        (i_in_b),
      .o_core_start  (o_core_start),
      .o_core_a      (o_core_a),
      .o_core_b      (o_core_b),
      .i_core_done   (i_core_done),
      .i_core_result (i_core_result),
      .o_out_valid   (o_out_valid),
      .i_out_ready   (i_out_ready),
      .o_out_result  (o_out_result),
      .o_busy        (o_busy)
`ifdef OPD_OP_COUNT_EN
      ,
      .o_op_count    (o_op_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
   endtask

   // Behavioural core: done with a*b six cycles after start; aborts on reset.
   initial begin : core_model
      logic [W-1:0] ca;
      logic [W-1:0] cb;
      bit           aborted;
      i_core_done   = 1'b0;
      i_core_result = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) continue;
         if (stray_req != stray_ack) begin
            stray_ack = stray_req;
            @(posedge clk); #1;
            i_core_done   = 1'b1;
            i_core_result = 32'hBAD0_BAD0;
            @(posedge clk); #1;
            i_core_done   = 1'b0;
            i_core_result = 32'h0;
         end else if (o_core_start) begin
            ca = o_core_a;
            cb = o_core_b;
            last_start_cyc = cyc;
            start_cnt++;
            @(negedge clk);
            chk("start_one_cycle", o_core_start, 0);
            aborted = 1'b0;
            repeat (5) begin
               @(posedge clk);
               if (!rst_n) aborted = 1'b1;
            end
            #1;
            if (!rst_n) aborted = 1'b1;
            if (!aborted) begin
               chk("core_a_stable", o_core_a, ca);
               chk("core_b_stable", o_core_b, cb);
               chk("valid_before_done", o_out_valid, 0);
               i_core_done   = 1'b1;
               i_core_result = 32'(ca) * 32'(cb);
               @(posedge clk); #1;
               i_core_done   = 1'b0;
               i_core_result = 32'h5A5A_5A5A;
               chk("valid_after_done", o_out_valid, 1);
            end
         end
      end
   end

   // Scoreboard monitor: every accepted output must match the oldest expected product.
   always @(negedge clk) begin
      logic [31:0] e;
      if (rst_n && o_out_valid && i_out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL result_unexpected: got 0x%0h, want no result", o_out_result);
         end else begin
            e = exp_q.pop_front();
            chk("result", o_out_result, e);
         end
      end
   end

   task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [31:0] e);
      bit ok = 1'b0;
      i_in_a     = a;
      i_in_b     = b;
      i_in_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (o_in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("push_accepted", o_in_ready, 1);
      if (ok) begin
         exp_q.push_back(e);
         t_acc = cyc;
      end
      @(posedge clk); #1;
      i_in_valid = 1'b0;
   endtask

   task automatic wait_starts(input int target);
      for (int k = 0; k < 40; k++) begin
         if (start_cnt >= target) break;
         @(posedge clk); #2;
      end
      chk("start_seen", start_cnt, target);
   endtask

   task automatic wait_valid();
      for (int k = 0; k < 60; k++) begin
         if (o_out_valid) break;
         @(posedge clk); #2;
      end
      chk("hold_reached", o_out_valid, 1);
   endtask

   task automatic drain();
      for (int k = 0; k < 400; k++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk); #2;
      end
      chk("drain", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, o_in_ready, 1);
      chk({tag, "_core_start"}, o_core_start, 0);
      chk({tag, "_core_a"}, o_core_a, 0);
      chk({tag, "_core_b"}, o_core_b, 0);
      chk({tag, "_out_valid"}, o_out_valid, 0);
      chk({tag, "_out_result"}, o_out_result, 0);
      chk({tag, "_busy"}, o_busy, 0);
`ifdef OPD_OP_COUNT_EN
      chk({tag, "_op_count"}, o_op_count, 0);
`endif
   endtask

   initial begin : main
      logic [31:0] r;
      int          sc;
      int          rel;
      int          acc0;
      bit          ok6;
      i_in_valid  = 1'b0;
      i_in_a      = '0;
      i_in_b      = '0;
      i_out_ready = 1'b1;

      // Power-on reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("por");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single operation: start two cycles after the push
      push(16'h0005, 16'h0003, 32'h0000_000F);
      wait_starts(1);
      chk("start_latency", last_start_cyc - t_acc, 2);
      drain();

      // FIFO fill with output stalled, then backpressure hold
      i_out_ready = 1'b0;
      acc0 = 0;
      for (int i = 0; i < 5; i++) begin
         push(fa[i], fb[i], fe[i]);
         if (i == 0) acc0 = t_acc;
      end
      chk("fill_back_to_back", t_acc - acc0, 4);
      i_in_a     = fa[5];
      i_in_b     = fb[5];
      i_in_valid = 1'b1;
      wait_valid();
      chk("full_in_ready", o_in_ready, 0);
      r  = o_out_result;
      sc = start_cnt;
      repeat (10) begin
         @(negedge clk);
         chk("bp_valid", o_out_valid, 1);
         chk("bp_result", o_out_result, r);
         chk("bp_in_ready", o_in_ready, 0);
      end
      chk("bp_no_start", start_cnt, sc);
      @(posedge clk); #1;
      i_out_ready = 1'b1;
      rel = cyc;
      ok6 = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (o_in_ready) begin
            ok6 = 1'b1;
            break;
         end
      end
      chk("sixth_accepted", o_in_ready, 1);
      if (ok6) exp_q.push_back(fe[5]);
      @(posedge clk); #1;
      i_in_valid = 1'b0;
      wait_starts(sc + 1);
      chk("reissue_latency", last_start_cyc - rel, 2);
      drain();

      // Stray done while idle
      @(posedge clk); #2;
      r  = o_out_result;
      sc = start_cnt;
      stray_req++;
      repeat (4) @(posedge clk);
      #2;
      chk("stray_idle_busy", o_busy, 0);
      chk("stray_idle_valid", o_out_valid, 0);
      chk("stray_idle_result", o_out_result, r);
      chk("stray_idle_no_start", start_cnt, sc);

      // Stray done while holding a result
      i_out_ready = 1'b0;
      push(16'h0003, 16'h0009, 32'h0000_001B);
      wait_valid();
      r  = o_out_result;
      sc = start_cnt;
      stray_req++;
      repeat (4) @(posedge clk);
      #2;
      chk("stray_hold_valid", o_out_valid, 1);
      chk("stray_hold_result", o_out_result, r);
      chk("stray_hold_busy", o_busy, 1);
      chk("stray_hold_no_start", start_cnt, sc);
      i_out_ready = 1'b1;
      drain();

`ifdef OPD_OP_COUNT_EN
      chk("op_count", o_op_count, 8);
`endif

      // Asynchronous reset while waiting on the core with three pairs queued
      push(16'h0011, 16'h0002, 32'h0000_0022);
      push(16'h0004, 16'h0004, 32'h0000_0010);
      push(16'h0006, 16'h0007, 32'h0000_002A);
      push(16'h0009, 16'h0009, 32'h0000_0051);
      chk("pre_reset_busy", o_busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      exp_q.delete();
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b1;
      sc = start_cnt;
      repeat (12) @(posedge clk);
      #2;
      chk("post_rst_busy", o_busy, 0);
      chk("post_rst_in_ready", o_in_ready, 1);
      chk("post_rst_valid", o_out_valid, 0);
      chk("post_rst_no_start", start_cnt, sc);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule
